seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the Nexys4 board. Accepts an unsigned binary value, converts it to BCD with an iterative shift-add-3 (double-dabble) engine, and time-multiplexes the resulting digits onto shared active-low cathodes with one-hot active-low anodes. Adds over the previous fixed 4-digit decoder:
- configurable digit count and input width;
- a refresh prescaler;
- leading-zero blanking, per-digit decimal points and overflow indication.

## Interface
- `DIGITS`, 8: number of display digits/anodes (1..8)
- `BIN_W`, 16: width of binary input (1..27)
- `REFRESH_DIV`, 100000: clk cycles each digit stays lit (≥2)
- `BLANK_LZ`, 1: 1 = blank leading zeros, 0 = show all digits
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `bin_in`  in  BIN_W  value to display, sampled on accepted `load`
- `load`  in  1  start conversion; accepted only when `busy`=0
- `dp_in`  in  DIGITS  decimal-point request per digit, 1 = on, sampled live
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse, display register updates at end of this cycle
- `overflow`  out  1  last converted value ≥ 10^DIGITS
- `anode`  out  DIGITS  one-hot active-low digit select
- `cathode`  out  7  segments {g,f,e,d,c,b,a}, active low
- `dp`  out  1  decimal point, active low

## Operation
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: on `load`=1, capture `bin_in` into the shift register, clear the BCD register (4*DIGITS bits) and the sticky overflow bit, load bit counter = BIN_W, then go to SHIFT.
  - SHIFT, each cycle:
    - add 3 to every BCD nibble ≥5;
    - shift {BCD, bin} left by one;
    - set sticky overflow if the bit shifted out of the BCD MSB is 1;
    - decrement the counter; at 1 go to DONE.
  - DONE: copy the BCD register to the display register and the sticky bit to `overflow`, then go to IDLE.
- `busy` = (state≠IDLE); `done` = (state==DONE). Both are registered decodes of the state.
- `load` in SHIFT/DONE is ignored; there is no queueing.
- Display register holds its value until the next DONE.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances; index DIGITS-1 wraps to 0.
- Digit glyphs (active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Overflow=1: every digit shows dash 0111111, and no blanking applies.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i>0 is blanked (1111111) when it and all higher digits are 0.
  - Digit 0 is never blanked.
- `dp` = ~dp_in[index]. Decimal points show on blanked digits too.
- Nibbles >9 cannot occur; decode them as blank.

## Timing
- Reset values: `anode` all 1, `cathode` 1111111, `dp` 1, `busy` 0, `done` 0, `overflow` 0; display register 0, index 0, prescaler 0, FSM IDLE.
- `anode`, `cathode` and `dp` are registered, one cycle behind index/data. First cycle after `rst` deasserts: `anode`=~(1<<0), `cathode`=1000000.
- Conversion latency:
  - `load` sampled at edge N;
  - `busy`=1 from N+1 through N+BIN_W+1;
  - `done`=1 in cycle N+BIN_W+1;
  - new glyphs appear on `cathode` no later than N+BIN_W+3.
- Back-to-back: `load` held high is re-accepted in the first IDLE cycle, i.e. one idle cycle between conversions.
- Digit change occurs exactly every REFRESH_DIV cycles. The display-register update does not reset the prescaler or index.
- `rst` mid-conversion aborts the conversion: FSM to IDLE, display register 0, `overflow` 0, no `done` pulse.
- `rst` wins over a simultaneous `load`.

## Test plan
- Reset release, DIGITS=4, BIN_W=16, REFRESH_DIV=4 -> first cycle: `anode`=1110, `cathode`=1000000, `busy`=0; `anode` rotates 1110→1101→1011→0111→1110 every 4 cycles.
- `load` `bin_in`=1234 -> `busy` high 17 cycles, `done` pulse in the 17th; scan shows digit0=0011001, digit1=0110000, digit2=0100100, digit3=1111001; `overflow`=0.
- `bin_in`=7, BLANK_LZ=1 -> digit0=1111000, digits1..3=1111111; same with BLANK_LZ=0 -> digits1..3=1000000; `dp_in`=0010 -> `dp`=0 only while `anode`=1101.
- `bin_in`=10000, DIGITS=4 -> `overflow`=1, all digits 0111111; next `load` of 9999 -> `overflow`=0, all digits 0010000.
- `load` 42 then `load` 99 pulsed 5 cycles later -> 99 ignored, display 42, exactly one `done`.
- Assert `rst` 8 cycles into converting 65535 -> `busy`=0, no `done`, display 0 (digit0 1000000, others blank); a new `load` 65535 with DIGITS=8 -> 6,5,5,3,5 on digits 4..0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double dabble) converter feeding a multiplexed active-low 7-segment scan.
// Conversion takes BIN_W+1 cycles after an accepted load; load is ignored while busy.
module seg7_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int BIN_W       = 16,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        cathode,
    output logic              dp
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_sticky_q, ovf_sticky_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, done_q;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        cathode_q, cathode_d;
    logic              dp_q, dp_d;

    logic [3:0]        nib_sel;
    logic              lz_sel;
    logic              dp_sel;
    logic              all_zero;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        disp_d       = disp_q;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d        = bin_in;
                    bcd_d        = '0;
                    ovf_sticky_d = 1'b0;
                    cnt_d        = CNT_INIT;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // A set bit leaving the top nibble means the value no longer fits in DIGITS digits.
                ovf_sticky_d = ovf_sticky_q | bcd_adj[BCD_W-1];
                bcd_d        = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d        = bin_q << 1;
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d     = bcd_q;
                overflow_d = ovf_sticky_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Walk from the most significant digit down so all_zero covers "this digit and every higher one".
    always_comb begin
        nib_sel  = 4'd0;
        lz_sel   = 1'b0;
        dp_sel   = 1'b0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (disp_q[4*i +: 4] == 4'd0);
            if (IDX_W'(i) == idx_q) begin
                nib_sel = disp_q[4*i +: 4];
                lz_sel  = all_zero && (i != 0);
                dp_sel  = dp_in[i];
            end
        end
    end

    always_comb begin
        anode_d = ~(DIGITS'(1) << idx_q);
        dp_d    = ~dp_sel;
        if (overflow_q) begin
            cathode_d = SEG_DASH;
        end else if (BLANK_LZ && lz_sel) begin
            cathode_d = SEG_BLANK;
        end else begin
            cathode_d = glyph(nib_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            disp_q       <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            presc_q      <= '0;
            idx_q        <= '0;
            anode_q      <= '1;
            cathode_q    <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            disp_q       <= disp_d;
            overflow_q   <= overflow_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            dp_q         <= dp_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign anode    = anode_q;
    assign cathode  = cathode_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: three driver instances (4 digits blanking, 4 digits no blanking, 8 digits) on shared stimulus.
module tb_seg7_scan_driver;
    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G6 = 7'h02, G7 = 7'h78, G9 = 7'h10;
    localparam logic [6:0] GB = 7'h7F, GD = 7'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bin_in;
    logic [3:0]  dp_in_a, dp_in_b;
    logic [7:0]  dp_in_c;

    logic       busy_a, done_a, ovf_a, dp_a;
    logic [3:0] anode_a;
    logic [6:0] cathode_a;
    logic       busy_b, done_b, ovf_b, dp_b;
    logic [3:0] anode_b;
    logic [6:0] cathode_b;
    logic       busy_c, done_c, ovf_c, dp_c;
    logic [7:0] anode_c;
    logic [6:0] cathode_c;

    int checks = 0;
    int errors = 0;
    int busy_cyc, done_cnt, done_at;

    logic [6:0] glyph_a [4];
    logic [6:0] glyph_b [4];
    logic [6:0] glyph_c [8];
    logic       dps_a   [4];

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .dp_in(dp_in_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .anode(anode_a), .cathode(cathode_a), .dp(dp_a)
    );

    seg7_scan_driver #(.DIGITS(4), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .dp_in(dp_in_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .anode(anode_b), .cathode(cathode_b), .dp(dp_b)
    );

    seg7_scan_driver #(.DIGITS(8), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_c (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .dp_in(dp_in_c),
        .busy(busy_c), .done(done_c), .overflow(ovf_c),
        .anode(anode_c), .cathode(cathode_c), .dp(dp_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge with load raised; samples 30 falling edges.
    task automatic run_conv(input logic [15:0] v, input int extra_at, input int rst_at);
        busy_cyc = 0;
        done_cnt = 0;
        done_at  = 0;
        bin_in   = v;
        load     = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            load = 1'b0;
            rst  = 1'b0;
            if (busy_a) busy_cyc++;
            if (done_a) begin
                done_cnt++;
                done_at = k;
            end
            if (k == extra_at) begin
                bin_in = 16'd99;
                load   = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    task automatic scan();
        logic [3:0] oh4;
        logic [7:0] oh8;
        for (int i = 0; i < 4; i++) begin
            glyph_a[i] = 7'h55;
            glyph_b[i] = 7'h55;
            dps_a[i]   = 1'bx;
        end
        for (int i = 0; i < 8; i++) glyph_c[i] = 7'h55;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                oh4 = 4'(1 << i);
                if (anode_a == ~oh4) begin
                    glyph_a[i] = cathode_a;
                    dps_a[i]   = dp_a;
                end
                if (anode_b == ~oh4) glyph_b[i] = cathode_b;
            end
            for (int i = 0; i < 8; i++) begin
                oh8 = 8'(1 << i);
                if (anode_c == ~oh8) glyph_c[i] = cathode_c;
            end
        end
    endtask

    task automatic chk_a(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, "_a_d0"}, 32'(glyph_a[0]), 32'(e0));
        chk({tag, "_a_d1"}, 32'(glyph_a[1]), 32'(e1));
        chk({tag, "_a_d2"}, 32'(glyph_a[2]), 32'(e2));
        chk({tag, "_a_d3"}, 32'(glyph_a[3]), 32'(e3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        logic [3:0] exp_an;
        rst     = 1'b1;
        load    = 1'b0;
        bin_in  = 16'd0;
        dp_in_a = 4'b0000;
        dp_in_b = 4'b0000;
        dp_in_c = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(anode_a), 32'hF);
        chk("rst_cathode", 32'(cathode_a), 32'h7F);
        chk("rst_dp", 32'(dp_a), 32'h1);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);

        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            oh     = 4'(1 << (((k - 1) / 4) % 4));
            exp_an = ~oh;
            chk($sformatf("scan_rot_%0d", k), 32'(anode_a), 32'(exp_an));
            if (k == 1) begin
                chk("first_cathode", 32'(cathode_a), 32'(G0));
                chk("first_busy", 32'(busy_a), 32'h0);
            end
        end

        run_conv(16'd1234, 0, 0);
        chk("c1234_busy_cycles", 32'(busy_cyc), 32'd17);
        chk("c1234_done_at", 32'(done_at), 32'd17);
        chk("c1234_done_cnt", 32'(done_cnt), 32'd1);
        chk("c1234_ovf", 32'(ovf_a), 32'h0);
        scan();
        chk_a("c1234", G1, G2, G3, G4);

        dp_in_a = 4'b0010;
        run_conv(16'd7, 0, 0);
        scan();
        chk_a("c7", GB, GB, GB, G7);
        chk("c7_b_d0", 32'(glyph_b[0]), 32'(G7));
        chk("c7_b_d1", 32'(glyph_b[1]), 32'(G0));
        chk("c7_b_d2", 32'(glyph_b[2]), 32'(G0));
        chk("c7_b_d3", 32'(glyph_b[3]), 32'(G0));
        chk("c7_dp0", 32'(dps_a[0]), 32'h1);
        chk("c7_dp1", 32'(dps_a[1]), 32'h0);
        chk("c7_dp2", 32'(dps_a[2]), 32'h1);
        chk("c7_dp3", 32'(dps_a[3]), 32'h1);
        dp_in_a = 4'b0000;

        run_conv(16'd10000, 0, 0);
        chk("c10000_ovf", 32'(ovf_a), 32'h1);
        scan();
        chk_a("c10000", GD, GD, GD, GD);

        run_conv(16'd9999, 0, 0);
        chk("c9999_ovf", 32'(ovf_a), 32'h0);
        scan();
        chk_a("c9999", G9, G9, G9, G9);

        run_conv(16'd42, 5, 0);
        chk("c42_done_cnt", 32'(done_cnt), 32'd1);
        chk("c42_busy_cycles", 32'(busy_cyc), 32'd17);
        scan();
        chk_a("c42", GB, GB, G4, G2);

        run_conv(16'd65535, 0, 8);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_busy_cycles", 32'(busy_cyc), 32'd8);
        chk("abort_ovf", 32'(ovf_a), 32'h0);
        scan();
        chk_a("abort", GB, GB, GB, G0);

        run_conv(16'd65535, 0, 0);
        chk("c65535_done_cnt", 32'(done_cnt), 32'd1);
        chk("c65535_a_ovf", 32'(ovf_a), 32'h1);
        chk("c65535_c_ovf", 32'(ovf_c), 32'h0);
        scan();
        chk("c65535_c_d0", 32'(glyph_c[0]), 32'(G5));
        chk("c65535_c_d1", 32'(glyph_c[1]), 32'(G3));
        chk("c65535_c_d2", 32'(glyph_c[2]), 32'(G5));
        chk("c65535_c_d3", 32'(glyph_c[3]), 32'(G5));
        chk("c65535_c_d4", 32'(glyph_c[4]), 32'(G6));
        chk("c65535_c_d5", 32'(glyph_c[5]), 32'(GB));
        chk("c65535_c_d7", 32'(glyph_c[7]), 32'(GB));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
